div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 37, giving the dividend, divisor, quotient and remainder width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester n holds a divide request.
REQ-005 The block SHALL have ports req0_dividend, req0_divisor, req1_dividend and req1_divisor, input, W each, the operands.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 each, a one-cycle accept pulse.
REQ-007 The block SHALL have ports resp0_done_tick / resp1_done_tick, output, 1 each, a one-cycle result-valid pulse.
REQ-008 The block SHALL have ports resp_quotient / resp_remainder, output, W each, and resp_err, output, 1, result of the last completed job.
REQ-009 The block SHALL have ports div_start, output, 1, and div_dividend / div_divisor, output, W each, which drive the shared divider.
REQ-010 The block SHALL have ports div_done_tick, input, 1, and div_quotient / div_remainder, input, W each, which come from the divider.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESPOND; any unused encoding SHALL return to IDLE.
REQ-013 In IDLE, when one or more valid requests are present, the FSM SHALL grant exactly one, pulse that requester's ready, latch its operands and id, and go to LAUNCH.
REQ-014 Arbitration SHALL be round-robin on a 1-bit last_grant: with both valid, grant the id != last_grant; with one valid, grant it; update last_grant on every grant.
REQ-015 In LAUNCH with divisor != 0: pulse div_start for exactly 1 cycle, go to WAIT.
REQ-016 div_dividend/div_divisor SHALL present the latched operands from LAUNCH until leaving WAIT.
REQ-017 In LAUNCH with divisor == 0: no div_start; quotient := all ones, remainder := dividend, err := 1; go to RESPOND.
REQ-018 In WAIT, div_done_tick SHALL capture div_quotient/div_remainder, set err := 0 and go to RESPOND; otherwise hold with no timeout.
REQ-019 In RESPOND, the granted requester's resp_done_tick SHALL pulse for 1 cycle, then the FSM SHALL return to IDLE.
REQ-020 resp_quotient/resp_remainder/resp_err SHALL be registered, valid from the done pulse, and held until the next RESPOND.
REQ-021 div_done_tick outside WAIT SHALL be ignored.
REQ-022 Latency SHALL be: ready at cycle k, div_start at k+1, done_tick 1 cycle after div_done_tick; zero-divisor done_tick at k+2.
REQ-023 A request SHALL NOT be accepted while busy; requesters SHALL hold valid and operands until ready, and operands are sampled only on the ready cycle.
REQ-024 A requester that reasserts valid in the cycle after its own done_tick SHALL still lose to a waiting other requester, per REQ-014.
REQ-025 At most one of ready/done_tick (across both requesters) SHALL be high in any cycle.

Reset
REQ-026 On rst_n low, asynchronously: state := IDLE, last_grant := 1 (so requester 0 wins the first tie), and all outputs/result registers := 0.
REQ-027 Reset mid-job SHALL abort it with no done_tick; the divider shares rst_n, so no pending div_done_tick survives.

Structure
REQ-028 A shared package SHALL hold the state encoding, default W = 37, and the zero-divide constants (all-ones quotient, err code).
REQ-029 The 2-way round-robin grant SHALL be a sub-module, rr_arb2 (inputs valid[1:0], last_grant; output grant id and grant-valid), which is combinational.
REQ-030 The divider SHALL be instantiated outside this block.

Verification
REQ-031 Scenario: req0 with 100000000000 / 50000, divider model of 40-cycle latency -> exactly 1 div_start, resp0_done_tick with quotient 2000000, remainder 0, err 0.
REQ-032 Scenario: req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1; the next simultaneous pair -> req1 first.
REQ-033 Scenario: req1 with 12345 / 0 -> no div_start, resp1_done_tick 2 cycles after ready, quotient all ones, remainder 12345, err 1.
REQ-034 Scenario: spurious div_done_tick in IDLE, then req0 7 / 2 -> stray pulse ignored; result is 3 remainder 1.
REQ-035 Scenario: rst_n low during WAIT -> busy 0 and all outputs 0 immediately; no done_tick; the next req0 completes normally.
REQ-036 Scenario: req1 held continuously while req0 job 9 / 3 runs -> req1 ready only after resp0_done_tick; one ready per job; no back-to-back overlap.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter_pkg
// Brief    : Shared types and constants for the two-requester divider front end.
// Revision : 1.0
// ============================================================================
package div_arbiter_pkg;

  localparam int C_DEFAULT_W = 37;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // A zero divisor yields a quotient with every bit set and a raised error flag.
  localparam logic C_ZDIV_Q_BIT = 1'b1;
  localparam logic C_ERR_NONE   = 1'b0;
  localparam logic C_ERR_ZDIV   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter_if
// Brief    : Requester, response and shared-divider signals of div_arbiter.
// Revision : 1.0
// ============================================================================
interface div_arbiter_if #(
  parameter int W = div_arbiter_pkg::C_DEFAULT_W
);
  logic         req0_valid;
  logic         req1_valid;
  logic [W-1:0] req0_dividend;
  logic [W-1:0] req0_divisor;
  logic [W-1:0] req1_dividend;
  logic [W-1:0] req1_divisor;
  logic         req0_ready;
  logic         req1_ready;
  logic         resp0_done_tick;
  logic         resp1_done_tick;
  logic [W-1:0] resp_quotient;
  logic [W-1:0] resp_remainder;
  logic         resp_err;
  logic         div_start;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_done_tick;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         busy;

  modport slave (
    input  req0_valid, req1_valid, req0_dividend, req0_divisor,
           req1_dividend, req1_divisor, div_done_tick, div_quotient, div_remainder,
    output req0_ready, req1_ready, resp0_done_tick, resp1_done_tick,
           resp_quotient, resp_remainder, resp_err,
           div_start, div_dividend, div_divisor, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_dividend, req0_divisor,
           req1_dividend, req1_divisor, div_done_tick, div_quotient, div_remainder,
    input  req0_ready, req1_ready, resp0_done_tick, resp1_done_tick,
           resp_quotient, resp_remainder, resp_err,
           div_start, div_dividend, div_divisor, busy
  );

endinterface
`default_nettype wire

// File: rtl/div_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin grant on a one-bit history.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Brief    : Shares one external divider between two requesters, round-robin.
// Revision : 1.0
// ============================================================================
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int W = C_DEFAULT_W
) (
  input logic          clk,
  input logic          rst_n,
  div_arbiter_if.slave bus
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_last_grant;
  logic         r_id;
  logic [W-1:0] r_dividend;
  logic [W-1:0] r_divisor;
  logic [W-1:0] r_quotient;
  logic [W-1:0] r_remainder;
  logic         r_err;

  logic         w_grant_id;
  logic         w_grant_valid;
  logic         w_accept;
  logic         w_div_start;
  logic         w_capture_div;
  logic         w_capture_zdiv;
  logic         w_respond;
  logic         w_div_active;

  rr_arb2 u_rr_arb2 (
    .valid       ({bus.req1_valid, bus.req0_valid}),
    .last_grant  (r_last_grant),
    .grant_id    (w_grant_id),
    .grant_valid (w_grant_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_div_start    = 1'b0;
    w_capture_div  = 1'b0;
    w_capture_zdiv = 1'b0;
    w_respond      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // A zero divisor never reaches the divider; the result is synthesized here.
        if (r_divisor == '0) begin
          w_capture_zdiv = 1'b1;
          w_state_next   = ST_RESPOND;
        end else begin
          w_div_start  = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.div_done_tick) begin
          w_capture_div = 1'b1;
          w_state_next  = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        w_respond    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_dividend   <= w_grant_id ? bus.req1_dividend : bus.req0_dividend;
        r_divisor    <= w_grant_id ? bus.req1_divisor  : bus.req0_divisor;
      end
      if (w_capture_zdiv) begin
        r_quotient  <= {W{C_ZDIV_Q_BIT}};
        r_remainder <= r_dividend;
        r_err       <= C_ERR_ZDIV;
      end else if (w_capture_div) begin
        r_quotient  <= bus.div_quotient;
        r_remainder <= bus.div_remainder;
        r_err       <= C_ERR_NONE;
      end
    end
  end

  assign w_div_active = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

  assign bus.req0_ready      = w_accept & ~w_grant_id;
  assign bus.req1_ready      = w_accept &  w_grant_id;
  assign bus.resp0_done_tick = w_respond & ~r_id;
  assign bus.resp1_done_tick = w_respond &  r_id;
  assign bus.resp_quotient   = r_quotient;
  assign bus.resp_remainder  = r_remainder;
  assign bus.resp_err        = r_err;
  assign bus.div_start       = w_div_start;
  assign bus.div_dividend    = w_div_active ? r_dividend : '0;
  assign bus.div_divisor     = w_div_active ? r_divisor  : '0;
  assign bus.busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Brief    : Randomized self-checking bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_div_arbiter;

  localparam int W = 37;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.W(W)) bus ();

  div_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  longint cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Model: one open job at a time, results computed with plain / and %.
  bit           m_last, m_open, m_done_next;
  bit           m_id;
  int           m_age;
  logic [W-1:0] m_a, m_b, m_q, m_r;
  logic         m_err;
  int           n_starts = 0;
  int           done_log[$];
  longint       ready_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    logic [1:0] er, ed;
    logic       es;
    bit         g;
    cycle++;
    er = 2'b00; ed = 2'b00; es = 1'b0; g = 1'b0;
    if (!rst_n) begin
      chk("rst_busy",  64'(bus.busy), 64'(0));
      chk("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
      chk("rst_done",  64'({bus.resp1_done_tick, bus.resp0_done_tick}), 64'(0));
      chk("rst_start", 64'(bus.div_start), 64'(0));
      chk("rst_quot",  64'(bus.resp_quotient), 64'(0));
      chk("rst_rem",   64'(bus.resp_remainder), 64'(0));
      chk("rst_err",   64'(bus.resp_err), 64'(0));
      m_last = 1'b1; m_open = 1'b0; m_done_next = 1'b0; m_age = 0;
      m_q = '0; m_r = '0; m_err = 1'b0;
    end else begin
      if (!m_open && (bus.req0_valid || bus.req1_valid)) begin
        g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        er[g] = 1'b1;
      end
      if (m_open) begin
        if (m_age == 1 && m_b != '0) es = 1'b1;
        if ((m_b == '0 && m_age == 2) || m_done_next) begin
          ed[m_id] = 1'b1;
          if (m_b == '0) begin
            m_q = '1; m_r = m_a; m_err = 1'b1;
          end else begin
            m_q = m_a / m_b; m_r = m_a % m_b; m_err = 1'b0;
          end
        end
      end
      chk("ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(er));
      chk("done",  64'({bus.resp1_done_tick, bus.resp0_done_tick}), 64'(ed));
      chk("div_start", 64'(bus.div_start), 64'(es));
      chk("busy", 64'(bus.busy), 64'(m_open));
      chk("resp_quotient", 64'(bus.resp_quotient), 64'(m_q));
      chk("resp_remainder", 64'(bus.resp_remainder), 64'(m_r));
      chk("resp_err", 64'(bus.resp_err), 64'(m_err));
      if (m_open && m_b != '0 && ed == 2'b00) begin
        chk("div_dividend", 64'(bus.div_dividend), 64'(m_a));
        chk("div_divisor",  64'(bus.div_divisor),  64'(m_b));
      end
      if (er != 2'b00) begin
        m_open = 1'b1; m_age = 1; m_id = g; m_last = g; m_done_next = 1'b0;
        m_a = g ? bus.req1_dividend : bus.req0_dividend;
        m_b = g ? bus.req1_divisor  : bus.req0_divisor;
        ready_cyc = cycle;
      end else if (m_open) begin
        if (ed != 2'b00) begin
          m_open = 1'b0; m_done_next = 1'b0;
          done_log.push_back(int'(m_id));
          done_cyc = cycle;
        end else begin
          m_done_next = (m_b != '0) && (m_age >= 2) && bus.div_done_tick;
          m_age++;
        end
      end
    end
    if (bus.div_start) n_starts++;
  end

  // Divider model with programmable latency and optional stray pulses in idle.
  int div_lat = 3;
  bit spur_req = 1'b0;
  initial begin
    int cnt;
    logic [W-1:0] a, b;
    cnt = 0; a = '0; b = '0;
    forever begin
      @(posedge clk); #1;
      bus.div_done_tick = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (spur_req && !bus.busy) begin
        bus.div_done_tick = 1'b1;
        bus.div_quotient  = W'($urandom);
        bus.div_remainder = W'($urandom);
        spur_req = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.div_done_tick = 1'b1;
          bus.div_quotient  = a / b;
          bus.div_remainder = a % b;
        end
      end
      if (rst_n && bus.div_start) begin
        cnt = div_lat; a = bus.div_dividend; b = bus.div_divisor;
      end
    end
  end

  logic [W-1:0] q0a[$], q0b[$], q1a[$], q1b[$];

  task automatic post(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin q1a.push_back(a); q1b.push_back(b); end
    else    begin q0a.push_back(a); q0b.push_back(b); end
  endtask

  // One clock: retire accepted requests, present the next queued one.
  task automatic tick();
    bit r0, r1;
    @(negedge clk); #1;
    r0 = bus.req0_ready; r1 = bus.req1_ready;
    @(posedge clk); #1;
    if (bus.req0_valid && r0) begin
      bus.req0_valid = 1'b0; bus.req0_dividend = W'($urandom); bus.req0_divisor = W'($urandom);
    end
    if (bus.req1_valid && r1) begin
      bus.req1_valid = 1'b0; bus.req1_dividend = W'($urandom); bus.req1_divisor = W'($urandom);
    end
    if (!bus.req0_valid && q0a.size() > 0) begin
      bus.req0_valid = 1'b1; bus.req0_dividend = q0a.pop_front(); bus.req0_divisor = q0b.pop_front();
    end
    if (!bus.req1_valid && q1a.size() > 0) begin
      bus.req1_valid = 1'b1; bus.req1_dividend = q1a.pop_front(); bus.req1_divisor = q1b.pop_front();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick(); n++;
    end while ((q0a.size() > 0 || q1a.size() > 0 || bus.req0_valid || bus.req1_valid || bus.busy)
               && n < budget);
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: timeout after %0d cycles, busy=%0b", n, bus.busy);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < done_log.size()) ? done_log[i] : -1;
  endfunction

  function automatic logic [W-1:0] rand_op(input bit is_divisor);
    logic [63:0] t;
    int unsigned sel;
    t = {$urandom, $urandom};
    sel = $urandom_range(0, 5);
    if (is_divisor && sel == 0) return '0;
    if (sel <= 2) return W'($urandom_range(1, 100));
    return (t[W-1:0] == '0) ? W'(1) : t[W-1:0];
  endfunction

  initial begin
    int base, s, n;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_dividend = '0; bus.req0_divisor = '0;
    bus.req1_dividend = '0; bus.req1_divisor = '0;
    bus.div_done_tick = 1'b0; bus.div_quotient = '0; bus.div_remainder = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous pair straight after reset: requester 0 wins.
    base = done_log.size();
    post(0, 20, 3); post(1, 50, 7);
    wait_idle(200);
    chk("pair1_first", 64'(log_at(base)), 64'(0));
    chk("pair1_second", 64'(log_at(base + 1)), 64'(1));
    chk("pair1_quot", 64'(bus.resp_quotient), 64'(7));

    // Large divide through a 40-cycle divider.
    div_lat = 40; s = n_starts; base = done_log.size();
    post(0, 37'd100000000000, 37'd50000);
    wait_idle(300);
    chk("big_starts", 64'(n_starts - s), 64'(1));
    chk("big_id", 64'(log_at(base)), 64'(0));
    chk("big_quot", 64'(bus.resp_quotient), 64'(2000000));
    chk("big_rem", 64'(bus.resp_remainder), 64'(0));
    chk("big_err", 64'(bus.resp_err), 64'(0));

    // Last grant was requester 0, so the next tie goes to requester 1.
    div_lat = 3; base = done_log.size();
    post(0, 100, 9); post(1, 200, 11);
    wait_idle(200);
    chk("pair2_first", 64'(log_at(base)), 64'(1));
    chk("pair2_second", 64'(log_at(base + 1)), 64'(0));

    // Zero divisor.
    s = n_starts; base = done_log.size();
    post(1, 12345, 0);
    wait_idle(100);
    chk("zdiv_starts", 64'(n_starts - s), 64'(0));
    chk("zdiv_id", 64'(log_at(base)), 64'(1));
    chk("zdiv_latency", 64'(done_cyc - ready_cyc), 64'(2));
    chk("zdiv_quot", 64'(bus.resp_quotient), 64'(37'h1F_FFFF_FFFF));
    chk("zdiv_rem", 64'(bus.resp_remainder), 64'(12345));
    chk("zdiv_err", 64'(bus.resp_err), 64'(1));

    // Stray divider pulse while idle.
    spur_req = 1'b1;
    tick(); tick();
    post(0, 7, 2);
    wait_idle(100);
    chk("spur_quot", 64'(bus.resp_quotient), 64'(3));
    chk("spur_rem", 64'(bus.resp_remainder), 64'(1));
    chk("spur_err", 64'(bus.resp_err), 64'(0));

    // Requester 1 arrives and holds while requester 0 is in flight.
    div_lat = 6; base = done_log.size();
    post(0, 9, 3);
    n = 0;
    do begin tick(); n++; end while ((bus.req0_valid || q0a.size() > 0) && n < 50);
    post(1, 30, 4);
    wait_idle(200);
    chk("hold_first", 64'(log_at(base)), 64'(0));
    chk("hold_second", 64'(log_at(base + 1)), 64'(1));
    chk("hold_quot", 64'(bus.resp_quotient), 64'(7));
    chk("hold_rem", 64'(bus.resp_remainder), 64'(2));

    // Reset while the divider is busy.
    div_lat = 40; base = done_log.size();
    post(0, 1000, 7);
    repeat (6) tick();
    chk("pre_reset_busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_quot", 64'(bus.resp_quotient), 64'(0));
    chk("reset_err", 64'(bus.resp_err), 64'(0));
    chk("reset_div_divisor", 64'(bus.div_divisor), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_no_done", 64'(done_log.size()), 64'(base));
    div_lat = 4;
    post(0, 45, 6);
    wait_idle(100);
    chk("post_reset_id", 64'(log_at(base)), 64'(0));
    chk("post_reset_quot", 64'(bus.resp_quotient), 64'(7));
    chk("post_reset_rem", 64'(bus.resp_remainder), 64'(3));

    // Randomized traffic.
    repeat (300) begin
      if ($urandom_range(0, 3) == 0 && q0a.size() < 2) post(0, rand_op(1'b0), rand_op(1'b1));
      if ($urandom_range(0, 3) == 0 && q1a.size() < 2) post(1, rand_op(1'b0), rand_op(1'b1));
      if ($urandom_range(0, 15) == 0) spur_req = 1'b1;
      div_lat = $urandom_range(1, 12);
      tick();
    end
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
